// File: rtl/uart_rx.sv
// uart_rx: serial receive stage of the UART.
// Oversamples the rx line, deframes start/data/parity/stop bits and delivers
// each byte with registered one-cycle status pulses.
//   clk, reset    : system clock, synchronous active-high reset
//   rx            : asynchronous serial input, idles high
//   BAUD          : oversample tick divisor (tick every BAUD+1 cycles)
//   PARITY_MODE   : 00/11 none, 01 even, 10 odd
//   STOP_BITS     : 00 one stop bit, otherwise two
//   RX_DATA       : last received byte, held until the next rx_done_tick
//   rx_done_tick  : byte valid pulse
//   PARITY_ERROR, FRAME_ERROR : pulses coincident with rx_done_tick
//   BREAK_ERROR   : break pulse, issued without rx_done_tick
//   rx_busy       : receiver engaged in a frame
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [31:0]          BAUD,
  input  logic [1:0]           PARITY_MODE,
  input  logic [1:0]           STOP_BITS,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 rx_done_tick,
  output logic                 PARITY_ERROR,
  output logic                 FRAME_ERROR,
  output logic                 BREAK_ERROR,
  output logic                 rx_busy
);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t               state, state_next;
  logic                 s1, s2;
  logic [31:0]          baud_q, baud_cnt;
  logic [1:0]           pmode_q;
  logic                 two_stop_q;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, stop_idx, ferr_acc;
  logic                 done_p, perr_p, ferr_p, brk_p;
  logic                 tick, half, full, parity_en, start_entry, brk_cond;
  logic                 done_set, brk_set;

  assign tick        = (baud_cnt == baud_q);
  assign half        = tick && (tick_cnt == HALF_LAST);
  assign full        = tick && (tick_cnt == FULL_LAST);
  assign parity_en   = pmode_q[0] ^ pmode_q[1];
  assign start_entry = (state == IDLE) && !s2;
  // Break is recognised on the first stop sample: every bit of the frame low.
  assign brk_cond    = !stop_idx && !s2 && (shreg == '0) && !(parity_en && par_bit);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (!s2) state_next = START;
      START:      if (half) state_next = s2 ? IDLE : DATA;
      DATA:       if (full && bit_cnt == LAST_BIT) state_next = parity_en ? PARITY : STOP;
      PARITY:     if (full) state_next = STOP;
      STOP: begin
        if (full) begin
          if (brk_cond)                   state_next = BREAK_WAIT;
          else if (stop_idx || !two_stop_q) state_next = IDLE;
        end
      end
      BREAK_WAIT: if (s2) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Busy extends over the completion stage and the output pulse cycle.
  always_comb begin
    rx_busy  = (state != IDLE) || done_p || rx_done_tick;
    done_set = 1'b0;
    brk_set  = 1'b0;
    if (state == STOP && full) begin
      done_set = (state_next == IDLE);
      brk_set  = (state_next == BREAK_WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b1;
      s2           <= 1'b1;
      baud_q       <= '0;
      baud_cnt     <= '0;
      pmode_q      <= '0;
      two_stop_q   <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      stop_idx     <= 1'b0;
      ferr_acc     <= 1'b0;
      done_p       <= 1'b0;
      perr_p       <= 1'b0;
      ferr_p       <= 1'b0;
      brk_p        <= 1'b0;
      RX_DATA      <= '0;
      rx_done_tick <= 1'b0;
      PARITY_ERROR <= 1'b0;
      FRAME_ERROR  <= 1'b0;
      BREAK_ERROR  <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      if (start_entry) begin
        baud_cnt   <= '0;
        tick_cnt   <= '0;
        bit_cnt    <= '0;
        stop_idx   <= 1'b0;
        ferr_acc   <= 1'b0;
        baud_q     <= BAUD;
        pmode_q    <= PARITY_MODE;
        two_stop_q <= |STOP_BITS;
      end else if (state != IDLE && state != BREAK_WAIT) begin
        baud_cnt <= tick ? '0 : baud_cnt + 32'd1;
        if (tick) begin
          if ((state == START && half) || full) tick_cnt <= '0;
          else                                  tick_cnt <= tick_cnt + TW'(1);
        end
        if (state == DATA && full) begin
          shreg   <= {s2, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
        if (state == PARITY && full) par_bit <= s2;
        if (state == STOP && full) begin
          stop_idx <= 1'b1;
          ferr_acc <= ferr_acc | ~s2;
        end
      end
      // Completion stage: flags captured on the final stop sample, driven out next cycle.
      done_p <= done_set;
      brk_p  <= brk_set;
      // pmode_q[1] flips the sense for odd parity.
      perr_p <= done_set && parity_en && (par_bit ^ (^shreg) ^ pmode_q[1]);
      ferr_p <= done_set && (ferr_acc || !s2);
      rx_done_tick <= done_p;
      PARITY_ERROR <= perr_p;
      FRAME_ERROR  <= ferr_p;
      BREAK_ERROR  <= brk_p;
      if (done_p) RX_DATA <= shreg;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] BAUD;
  logic [1:0]  PARITY_MODE;
  logic [1:0]  STOP_BITS;
  logic [7:0]  RX_DATA;
  logic        rx_done_tick, PARITY_ERROR, FRAME_ERROR, BREAK_ERROR, rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         at;
  } exp_t;
  exp_t q[$];
  logic [7:0] last_data;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .BAUD(BAUD),
    .PARITY_MODE(PARITY_MODE), .STOP_BITS(STOP_BITS),
    .RX_DATA(RX_DATA), .rx_done_tick(rx_done_tick),
    .PARITY_ERROR(PARITY_ERROR), .FRAME_ERROR(FRAME_ERROR),
    .BREAK_ERROR(BREAK_ERROR), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, want);
    end
  endtask

  // Observed at the negedge following the done edge, relative to the negedge where
  // the start bit is driven: final sample tick T, entry 2 edges after rx is seen.
  function automatic int lat(input int pen, input int nstop, input int b);
    int t;
    t = 8 + 16 * (8 + pen + nstop);
    return 1 + 3 + t * (b + 1);
  endfunction

  task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic br, input int at);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.brk = br; e.at = at;
    q.push_back(e);
    if (!br) last_data = d;
  endtask

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int pen, input logic p,
                            input int nstop, input logic stopv, input int bitc);
    send_bit(1'b0, bitc);
    for (int i = 0; i < 8; i++) send_bit(d[i], bitc);
    if (pen != 0) send_bit(p, bitc);
    for (int s = 0; s < nstop; s++) send_bit(stopv, bitc);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) chk("pulse_width", {rx_done_tick, BREAK_ERROR, PARITY_ERROR, FRAME_ERROR}, 0);
      prev = 1'b0;
      if (rx_done_tick || BREAK_ERROR || PARITY_ERROR || FRAME_ERROR) begin
        prev = 1'b1;
        chk("event_expected", q.size() != 0, 1);
        if (q.size() != 0) e = q.pop_front();
        else begin
          e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b0; e.brk = 1'b0; e.at = -1;
        end
        chk("done_tick", rx_done_tick, !e.brk);
        chk("break_err", BREAK_ERROR, e.brk);
        chk("parity_err", PARITY_ERROR, e.perr);
        chk("frame_err", FRAME_ERROR, e.ferr);
        chk("rx_data", RX_DATA, e.data);
        if (e.at >= 0) chk("latency", cyc, e.at);
      end
    end
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; BAUD = 0; PARITY_MODE = 2'b00; STOP_BITS = 2'b00;
    last_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {RX_DATA, rx_done_tick, PARITY_ERROR, FRAME_ERROR, BREAK_ERROR, rx_busy}, 0);
    reset = 1'b0;
    fork monitor(); join_none
    repeat (10) @(negedge clk);

    // Clean 8N1 frame at BAUD=0
    push(8'hA5, 0, 0, 0, cyc + lat(0, 1, 0));
    send_frame(8'hA5, 0, 1'b0, 1, 1'b1, 16);
    wait_drain("drain_a5", 100);
    repeat (20) @(negedge clk);

    // Glitch of 4 ticks
    send_bit(1'b0, 4);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy", rx_busy, 1);
    repeat (40) @(negedge clk);
    chk("glitch_idle", rx_busy, 0);

    // Framing error, data still delivered
    push(8'h55, 0, 1, 0, cyc + lat(0, 1, 0));
    send_frame(8'h55, 0, 1'b0, 1, 1'b0, 16);
    wait_drain("drain_55", 100);
    repeat (40) @(negedge clk);

    // Break: 3 frame times low, RX_DATA must stay 0x55
    push(last_data, 0, 0, 1, -1);
    send_bit(1'b0, 480);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    wait_drain("drain_break", 10);
    chk("busy_after_break", rx_busy, 0);
    push(8'h12, 0, 0, 0, cyc + lat(0, 1, 0));
    send_frame(8'h12, 0, 1'b0, 1, 1'b1, 16);
    wait_drain("drain_12", 100);
    repeat (20) @(negedge clk);

    // Even parity, two stop bits, BAUD=3
    BAUD = 3; PARITY_MODE = 2'b01; STOP_BITS = 2'b01;
    push(8'h3C, 0, 0, 0, cyc + lat(1, 2, 3));
    send_frame(8'h3C, 1, 1'b0, 2, 1'b1, 64);
    wait_drain("drain_3c_ok", 200);
    repeat (20) @(negedge clk);
    push(8'h3C, 1, 0, 0, cyc + lat(1, 2, 3));
    send_frame(8'h3C, 1, 1'b1, 2, 1'b1, 64);
    wait_drain("drain_3c_perr", 200);
    repeat (20) @(negedge clk);

    // Reset in the middle of the data bits
    BAUD = 0; PARITY_MODE = 2'b00; STOP_BITS = 2'b00;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 8);
    chk("busy_mid_frame", rx_busy, 1);
    reset = 1'b1; rx = 1'b1;
    @(negedge clk);
    chk("reset_mid_frame", {RX_DATA, rx_done_tick, PARITY_ERROR, FRAME_ERROR, BREAK_ERROR, rx_busy}, 0);
    reset = 1'b0;
    last_data = 8'h00;
    repeat (20) @(negedge clk);
    push(8'h81, 0, 0, 0, cyc + lat(0, 1, 0));
    send_frame(8'h81, 0, 1'b0, 1, 1'b1, 16);
    wait_drain("drain_81", 100);
    repeat (20) @(negedge clk);

    // BAUD changed mid-frame: current frame keeps BAUD=1, next uses BAUD=5
    BAUD = 1;
    fork
      begin
        repeat (60) @(negedge clk);
        BAUD = 5;
      end
    join_none
    push(8'h6B, 0, 0, 0, cyc + lat(0, 1, 1));
    send_frame(8'h6B, 0, 1'b0, 1, 1'b1, 32);
    wait_drain("drain_6b", 200);
    repeat (30) @(negedge clk);
    push(8'h3A, 0, 0, 0, cyc + lat(0, 1, 5));
    send_frame(8'h3A, 0, 1'b0, 1, 1'b1, 96);
    wait_drain("drain_3a", 400);
    repeat (20) @(negedge clk);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
